mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
- Accepts requests from both, grants one at a time, drives a registered memory request, waits for a variable-latency acknowledge, and routes the read data or write completion back to the winner.
- Data accesses have priority. A bounded-starvation counter guarantees forward progress of fetch.
- Sits between the core's fetch/LSU and the memory model. It is the first step toward a multi-cycle core built on the existing datapath.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits (byte enables are DW/8 wide)
- STARVE_MAX, 4, max consecutive data grants while fetch waits; legal range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address (word aligned)
- if_gnt  out  1  one-cycle pulse: fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  store byte enables (ignored for loads)
- d_gnt  out  1  one-cycle pulse: data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete
- d_rdata  out  DW  load data (0 on store completion)
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  AW  memory address, registered
- m_wdata  out  DW  memory write data, registered
- m_be  out  DW/8  memory byte enables, registered (all ones for reads)
- m_ack  in  1  memory accepts/completes the current request; one pulse per request
- m_rdata  in  DW  read data, valid in the m_ack cycle
- busy  out  1  high while a transaction is outstanding (state != IDLE)

Behaviour:
- States: IDLE, I_WAIT, D_WAIT.
- IDLE, arbitration (combinational, same cycle):
  - Fetch wins if if_req and (!d_req or starve_cnt == STARVE_MAX).
  - Otherwise data wins if d_req.
  - Winner's gnt pulses high this cycle only.
- On the grant edge:
  - m_* registers load the winner's payload; m_req goes 1.
  - State moves to I_WAIT or D_WAIT.
  - A fetch grant loads m_we = 0 and m_be = all ones.
- starve_cnt update on each grant edge:
  - Data grant with if_req high: increment, saturating at STARVE_MAX.
  - Fetch grant, or data grant with if_req low: clear to 0.
- I_WAIT / D_WAIT:
  - m_* held stable; gnt outputs are 0; new requests are not accepted.
  - On m_ack: capture m_rdata into the rdata register (capture 0 for stores), clear m_req, return to IDLE.
  - The matching rvalid pulses high for exactly the cycle after m_ack. rdata holds its value until the next capture.
- Back-to-back: the IDLE cycle in which rvalid is high may grant a new request, giving a throughput of one transaction per (memory latency + 1) cycles.
- Latency with a zero-wait memory (m_ack high in the first m_req cycle): gnt at T0, m_req at T1, m_ack at T1, rvalid at T2.
- m_ack sampled in IDLE is ignored.
- Requests dropped before being granted are legal and cause no transaction.
- Simultaneous if_req and d_req with starve_cnt < STARVE_MAX: data wins. Fetch stays pending and is served at the next IDLE unless data wins again.
- Reset (also mid-transaction): state IDLE; m_req, m_we, gnts, rvalids, busy = 0; m_addr, m_wdata, rdata = 0; m_be = 0; starve_cnt = 0. An outstanding m_ack after reset is ignored.
- Width rules: addresses and data pass through unmodified; no alignment checks.

Test Plan:
- Single fetch, if_addr = 0x0000_0010, memory acks 0 cycles after m_req with m_rdata = 0x0050_0093 -> if_gnt at T0, m_req at T1 with m_addr = 0x10, m_we = 0, if_rvalid at T2 with if_rdata = 0x0050_0093, busy high T1 only.
- Store d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_be = 4'b0011, ack after 3 wait cycles -> m_we = 1, m_be = 0011, m_wdata = DEADBEEF held stable 4 cycles; d_rvalid one cycle after ack, d_rdata = 0.
- Simultaneous if_req and d_req at T0 -> d_gnt at T0, if_gnt not asserted until the next IDLE cycle, fetch served second.
- d_req held continuously plus if_req, STARVE_MAX = 4, zero-wait memory -> exactly 4 data grants, then if_gnt, then starve_cnt = 0 and data wins again.
- rst asserted during D_WAIT before m_ack, m_ack arrives the cycle after reset release -> m_req = 0, busy = 0, no d_rvalid, starve_cnt = 0.
- Back-to-back loads on a zero-wait memory -> new d_gnt in the same cycle as the previous d_rvalid, one grant every 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between the instruction-fetch port
// and the load/store data port. One transaction is outstanding at a time.
// Data requests have priority, but after STARVE_MAX consecutive data grants
// with fetch waiting, fetch is guaranteed the next grant.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // instruction fetch port
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // load/store data port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // memory side
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_ack,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  localparam int         BW         = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [3:0]      starve_q,    starve_d;
  logic            m_req_q,     m_req_d;
  logic            m_we_q,      m_we_d;
  logic [AW-1:0]   m_addr_q,    m_addr_d;
  logic [DW-1:0]   m_wdata_q,   m_wdata_d;
  logic [BW-1:0]   m_be_q,      m_be_d;
  logic [DW-1:0]   rdata_q,     rdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q,  d_rvalid_d;

  // Count of consecutive data grants taken while fetch was waiting;
  // saturates so fetch wins as soon as the limit is reached.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  // Same-cycle arbitration in IDLE: data first unless fetch has starved.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (if_req && (!d_req || starve_q == STARVE_LIM)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Next-state: load the winner's payload on grant, complete on m_ack.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_be_d      = m_be_q;
    rdata_d     = rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // m_ack seen here belongs to no transaction and is ignored
        if (if_gnt) begin
          state_d   = I_WAIT;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
          starve_d  = 4'd0;
        end else if (d_gnt) begin
          state_d   = D_WAIT;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_we ? d_be : '1;
          starve_d  = if_req ? sat_inc(starve_q) : 4'd0;
        end
      end
      I_WAIT, D_WAIT: begin
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          // store completion returns zero data
          rdata_d = m_we_q ? '0 : m_rdata;
          if (state_q == I_WAIT) begin
            if_rvalid_d = 1'b1;
          end else begin
            d_rvalid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State register; reset also aborts an outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_be_q      <= '0;
      rdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_be_q      <= m_be_d;
      rdata_q     <= rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed cycle table, hand-written
// starvation and mid-transaction reset sequences, and a randomized run
// against a transaction-level reference model with a small memory.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic            clk, rst;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt, if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            d_req, d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_gnt, d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            m_req, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_be;
  logic            m_ack;
  logic [DW-1:0]   m_rdata;
  logic            busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b, expected %0b", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_ack = 1'b0; m_rdata = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, " m_req"}, m_req, 1'b0);
    chk1({tag, " m_we"}, m_we, 1'b0);
    chk32({tag, " m_addr"}, m_addr, 32'h0);
    chk32({tag, " m_wdata"}, m_wdata, 32'h0);
    chk32({tag, " m_be"}, 32'(m_be), 32'h0);
    chk1({tag, " if_gnt"}, if_gnt, 1'b0);
    chk1({tag, " d_gnt"}, d_gnt, 1'b0);
    chk1({tag, " if_rvalid"}, if_rvalid, 1'b0);
    chk1({tag, " d_rvalid"}, d_rvalid, 1'b0);
    chk32({tag, " if_rdata"}, if_rdata, 32'h0);
    chk32({tag, " d_rdata"}, d_rdata, 32'h0);
    chk1({tag, " busy"}, busy, 1'b0);
  endtask

  // Two reset edges, reset state checked while rst is still high.
  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset(tag);
    adv();
    rst = 1'b0;
  endtask

  // One directed cycle: inputs applied this cycle and outputs expected this cycle
  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        ack;
    logic [31:0] mrd;
    logic        igt;
    logic        dgt;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic        irv;
    logic        drv;
    logic [31:0] rd;
    logic        busy;
  } row_t;

  row_t rows[$];
  row_t r;

  function automatic row_t with_m(input row_t x, input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] be);
    x.mreq = 1'b1; x.busy = 1'b1; x.mwe = we; x.maddr = a; x.mwdata = wd; x.mbe = be;
    return x;
  endfunction

  // randomized-run state
  logic [31:0] mem [64];
  bit          ip, dp, dwe_v;
  logic [31:0] ia, da, dwd;
  logic [3:0]  dbe_v;
  int          wcnt, lat;
  bit          mb_busy, mb_port, mb_we;
  logic [31:0] mb_addr, mb_wdata;
  logic [3:0]  mb_be;
  int          starve;
  bit          rv_i, rv_d, eig, edg;
  logic [31:0] exp_rd_i, exp_rd_d, exp_read;

  initial begin
    rst = 1'b1;
    clear_inputs();

    // ---------------- directed table ----------------
    // single fetch, zero-wait memory
    r = '0; r.ireq = 1; r.iaddr = 32'h10; r.igt = 1; rows.push_back(r);
    r = '0; r.ack = 1; r.mrd = 32'h0050_0093; r = with_m(r, 1'b0, 32'h10, 32'h0, 4'hF); rows.push_back(r);
    r = '0; r.irv = 1; r.rd = 32'h0050_0093; rows.push_back(r);
    r = '0; rows.push_back(r);
    // store with three wait cycles
    r = '0; r.dreq = 1; r.dwe = 1; r.daddr = 32'h100; r.dwdata = 32'hDEAD_BEEF; r.dbe = 4'b0011;
    r.dgt = 1; rows.push_back(r);
    for (int k = 0; k < 3; k++) begin
      r = '0; r = with_m(r, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011); rows.push_back(r);
    end
    r = '0; r.ack = 1; r.mrd = 32'h1234_5678; r = with_m(r, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
    rows.push_back(r);
    r = '0; r.drv = 1; r.rd = 32'h0; rows.push_back(r);
    r = '0; rows.push_back(r);
    // simultaneous requests: data first, fetch at next IDLE
    r = '0; r.ireq = 1; r.iaddr = 32'h20; r.dreq = 1; r.daddr = 32'h200; r.dgt = 1; rows.push_back(r);
    r = '0; r.ireq = 1; r.iaddr = 32'h20; r.ack = 1; r.mrd = 32'hAAAA_0001;
    r = with_m(r, 1'b0, 32'h200, 32'h0, 4'hF); rows.push_back(r);
    r = '0; r.ireq = 1; r.iaddr = 32'h20; r.igt = 1; r.drv = 1; r.rd = 32'hAAAA_0001; rows.push_back(r);
    r = '0; r.ack = 1; r.mrd = 32'hBBBB_0002; r = with_m(r, 1'b0, 32'h20, 32'h0, 4'hF); rows.push_back(r);
    r = '0; r.irv = 1; r.rd = 32'hBBBB_0002; rows.push_back(r);
    // back-to-back loads, zero-wait memory
    r = '0; r.dreq = 1; r.daddr = 32'h300; r.dgt = 1; rows.push_back(r);
    r = '0; r.dreq = 1; r.daddr = 32'h304; r.ack = 1; r.mrd = 32'h11;
    r = with_m(r, 1'b0, 32'h300, 32'h0, 4'hF); rows.push_back(r);
    r = '0; r.dreq = 1; r.daddr = 32'h304; r.dgt = 1; r.drv = 1; r.rd = 32'h11; rows.push_back(r);
    r = '0; r.ack = 1; r.mrd = 32'h22; r = with_m(r, 1'b0, 32'h304, 32'h0, 4'hF); rows.push_back(r);
    r = '0; r.drv = 1; r.rd = 32'h22; rows.push_back(r);
    // stray m_ack in IDLE
    r = '0; r.ack = 1; r.mrd = 32'h99; rows.push_back(r);
    r = '0; rows.push_back(r);

    do_reset("reset");

    foreach (rows[i]) begin
      r = rows[i];
      if_req = r.ireq; if_addr = r.iaddr;
      d_req = r.dreq; d_we = r.dwe; d_addr = r.daddr; d_wdata = r.dwdata; d_be = r.dbe;
      m_ack = r.ack; m_rdata = r.mrd;
      @(negedge clk);
      chk1($sformatf("row%0d if_gnt", i), if_gnt, r.igt);
      chk1($sformatf("row%0d d_gnt", i), d_gnt, r.dgt);
      chk1($sformatf("row%0d m_req", i), m_req, r.mreq);
      chk1($sformatf("row%0d busy", i), busy, r.busy);
      chk1($sformatf("row%0d if_rvalid", i), if_rvalid, r.irv);
      chk1($sformatf("row%0d d_rvalid", i), d_rvalid, r.drv);
      if (r.mreq) begin
        chk1($sformatf("row%0d m_we", i), m_we, r.mwe);
        chk32($sformatf("row%0d m_addr", i), m_addr, r.maddr);
        chk32($sformatf("row%0d m_be", i), 32'(m_be), 32'(r.mbe));
        if (r.mwe) chk32($sformatf("row%0d m_wdata", i), m_wdata, r.mwdata);
      end
      if (r.irv) chk32($sformatf("row%0d if_rdata", i), if_rdata, r.rd);
      if (r.drv) chk32($sformatf("row%0d d_rdata", i), d_rdata, r.rd);
      adv();
    end
    clear_inputs();

    // ---------------- starvation bound ----------------
    // both ports request continuously: D D D D I D D D D I
    do_reset("pre-starve");
    for (int k = 0; k < 10; k++) begin
      if_req = 1'b1; if_addr = 32'h1000 + 32'((k / 5) * 4);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; m_ack = 1'b0;
      @(negedge clk);
      chk1($sformatf("starve grant%0d if_gnt", k), if_gnt, (k % 5) == 4);
      chk1($sformatf("starve grant%0d d_gnt", k), d_gnt, (k % 5) != 4);
      if (k > 0) chk1($sformatf("starve grant%0d if_rvalid", k), if_rvalid, ((k - 1) % 5) == 4);
      adv();
      m_ack = 1'b1; m_rdata = 32'(k);
      @(negedge clk);
      chk1($sformatf("starve wait%0d busy", k), busy, 1'b1);
      adv();
      m_ack = 1'b0;
    end
    clear_inputs();

    // ---------------- reset during D_WAIT ----------------
    do_reset("pre-rst");
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500 + 32'(k * 4);
      @(negedge clk);
      chk1($sformatf("rstseq grant%0d d_gnt", k), d_gnt, 1'b1);
      chk1($sformatf("rstseq grant%0d if_gnt", k), if_gnt, 1'b0);
      adv();
      if_req = 1'b0; d_req = 1'b0;
      if (k < 3) begin
        m_ack = 1'b1; m_rdata = 32'(k);
        adv();
        m_ack = 1'b0;
      end
    end
    @(negedge clk);
    chk1("rstseq busy before rst", busy, 1'b1);
    adv();
    rst = 1'b1;
    adv();
    @(negedge clk);
    chk_reset("rstseq in reset");
    adv();
    rst = 1'b0; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk1("rstseq late ack busy", busy, 1'b0);
    chk1("rstseq late ack m_req", m_req, 1'b0);
    chk1("rstseq late ack d_rvalid", d_rvalid, 1'b0);
    adv();
    m_ack = 1'b0;
    @(negedge clk);
    chk1("rstseq after ack d_rvalid", d_rvalid, 1'b0);
    chk1("rstseq after ack busy", busy, 1'b0);
    adv();
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h600;
    @(negedge clk);
    chk1("rstseq starve cleared d_gnt", d_gnt, 1'b1);
    chk1("rstseq starve cleared if_gnt", if_gnt, 1'b0);
    adv();
    if_req = 1'b0; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h1;
    adv();
    clear_inputs();
    adv();

    // ---------------- randomized run vs reference model ----------------
    do_reset("pre-random");
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    ip = 0; dp = 0; dwe_v = 0; ia = '0; da = '0; dwd = '0; dbe_v = '0;
    wcnt = 0; lat = $urandom_range(3);
    mb_busy = 0; mb_port = 0; mb_we = 0; mb_addr = '0; mb_wdata = '0; mb_be = '0;
    starve = 0; rv_i = 0; rv_d = 0; exp_rd_i = '0; exp_rd_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // requesters: hold until granted, occasionally withdraw
      if (!ip) begin
        if ($urandom_range(2) == 0) begin ip = 1; ia = {24'h0, 6'($urandom_range(63)), 2'b00}; end
      end else if ($urandom_range(19) == 0) ip = 0;
      if (!dp) begin
        if ($urandom_range(1) == 0) begin
          dp = 1; dwe_v = 1'($urandom_range(1)); da = {24'h0, 6'($urandom_range(63)), 2'b00};
          dwd = $urandom; dbe_v = 4'($urandom_range(15));
        end
      end else if ($urandom_range(19) == 0) dp = 0;
      if_req = ip; if_addr = ip ? ia : $urandom;
      d_req = dp; d_we = dwe_v; d_addr = dp ? da : $urandom; d_wdata = dwd; d_be = dbe_v;
      // memory responder with random latency, plus stray acks when idle
      if (m_req) begin
        m_ack = (wcnt == lat);
        m_rdata = (m_ack && !m_we) ? mem[m_addr[7:2]] : $urandom;
      end else begin
        m_ack = ($urandom_range(9) == 0);
        m_rdata = $urandom;
      end
      exp_read = mem[mb_addr[7:2]];
      @(negedge clk);
      eig = !mb_busy && ip && (!dp || starve == SMAX);
      edg = !mb_busy && dp && !eig;
      chk1("rnd if_gnt", if_gnt, eig);
      chk1("rnd d_gnt", d_gnt, edg);
      chk1("rnd m_req", m_req, mb_busy);
      chk1("rnd busy", busy, mb_busy);
      chk1("rnd if_rvalid", if_rvalid, rv_i);
      chk1("rnd d_rvalid", d_rvalid, rv_d);
      if (rv_i) chk32("rnd if_rdata", if_rdata, exp_rd_i);
      if (rv_d) chk32("rnd d_rdata", d_rdata, exp_rd_d);
      if (mb_busy) begin
        chk1("rnd m_we", m_we, mb_we);
        chk32("rnd m_addr", m_addr, mb_addr);
        chk32("rnd m_be", 32'(m_be), 32'(mb_be));
        if (mb_we) chk32("rnd m_wdata", m_wdata, mb_wdata);
      end
      // memory side effects
      if (m_req && m_ack && m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
      end
      if (m_req) begin
        if (m_ack) begin wcnt = 0; lat = $urandom_range(3); end
        else wcnt++;
      end else wcnt = 0;
      // reference model: one transaction at a time, starvation count on grants
      rv_i = 0; rv_d = 0;
      if (mb_busy) begin
        if (m_ack) begin
          mb_busy = 0;
          if (!mb_port) begin rv_i = 1; exp_rd_i = exp_read; end
          else begin rv_d = 1; exp_rd_d = mb_we ? 32'h0 : exp_read; end
        end
      end else if (eig) begin
        mb_busy = 1; mb_port = 0; mb_we = 0; mb_addr = ia; mb_be = 4'hF; starve = 0;
      end else if (edg) begin
        mb_busy = 1; mb_port = 1; mb_we = dwe_v; mb_addr = da; mb_wdata = dwd;
        mb_be = dwe_v ? dbe_v : 4'hF;
        starve = ip ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
      end
      if (eig) ip = 0;
      if (edg) dp = 0;
      adv();
    end
    clear_inputs();
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
